// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants and types for the ALU scheduler.
//   - DATA_W / OP_W : fixed datapath and opcode widths
//   - OP_ADD..OP_MUL: legal ALU opcodes, OP_LAST marks the highest legal one
//   - sched_state_t : scheduler FSM state encoding
//   - op_legal()    : opcode legality helper
package alu_sched_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd3;
  localparam logic [OP_W-1:0] OP_OR   = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd5;
  localparam logic [OP_W-1:0] OP_LAST = OP_MUL;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// alu_sched_arb: two-input grant logic for the ALU scheduler.
// Build option: ALU_SCHED_RR_EN
//   defined   -> round-robin; a pointer flop (ptr) gives priority to the
//                requester that did not win the last accepted grant.
//   undefined -> fixed priority, r0 always wins; no pointer flop, and the
//                clk/rst/take ports are not present.
// Ports:
//   clk, rst   clock / async active-high reset (round-robin build only)
//   take       a grant was accepted this cycle (round-robin build only)
//   req0, req1 request present
//   gnt0, gnt1 one-hot (or zero) grant, purely combinational
module alu_sched_arb (
`ifdef ALU_SCHED_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ALU_SCHED_RR_EN
  // ptr == 0: r0 has priority; ptr == 1: r1 has priority.
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take) begin
      // Winner r0 hands priority to r1 and vice versa.
      ptr <= gnt0;
    end
  end

  always_comb begin
    gnt0 = req0 && (!req1 || !ptr);
    gnt1 = req1 && !gnt0;
  end
`else
  always_comb begin
    gnt0 = req0;
    gnt1 = req1 && !req0;
  end
`endif

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one external combinational ALU between requesters r0/r1.
// Build option: ALU_SCHED_RR_EN selects round-robin arbitration (see
// alu_sched_arb); undefined gives fixed r0-first priority.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rX_valid/ready/op/a/b     request channels (X = 0, 1)
//   alu_op, alu_a, alu_b      drive to the ALU, non-zero only in EXEC
//   alu_out, alu_0_flag,
//   alu_o_flag                ALU result and flags
//   rsp_valid/ready/id/data/
//   rsp_z/rsp_o/rsp_err       tagged response channel
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid && ready; the producer holds its payload stable until then.
// FSM: S_IDLE (accept) -> S_EXEC (one ALU cycle) -> S_RESP (hold response).
// The current FSM state is visible on the internal signal `state`.
module alu_sched
  import alu_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_0_flag,
  input  logic              alu_o_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_o,
  output logic              rsp_err
);

  sched_state_t      state, state_next;
  logic              gnt0, gnt1;
  logic              accept;
  logic [OP_W-1:0]   sel_op;
  logic              sel_legal;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q, err_q;

  alu_sched_arb u_arb (
`ifdef ALU_SCHED_RR_EN
    .clk  (clk),
    .rst  (rst),
    .take (accept),
`endif
    .req0 (r0_valid),
    .req1 (r1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Grants only matter while idle; elsewhere requests wait with ready low.
  always_comb begin
    r0_ready  = (state == S_IDLE) && gnt0;
    r1_ready  = (state == S_IDLE) && gnt1;
    accept    = r0_ready || r1_ready;
    sel_op    = r1_ready ? r1_op : r0_op;
    sel_legal = op_legal(sel_op);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture. An illegal opcode is replaced by OP_ADD (0) so the ALU
  // never sees it; err_q remembers that the response must be an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= sel_legal ? sel_op : OP_ADD;
      a_q   <= r1_ready ? r1_a : r0_a;
      b_q   <= r1_ready ? r1_b : r0_b;
      id_q  <= r1_ready;
      err_q <= !sel_legal;
    end
  end

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (state == S_EXEC) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end
  end

  // Response capture at the end of the EXEC cycle; held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_z    <= 1'b0;
      rsp_o    <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_id   <= id_q;
      rsp_err  <= err_q;
      rsp_data <= err_q ? '0 : alu_out;
      rsp_z    <= !err_q && alu_0_flag;
      rsp_o    <= !err_q && alu_o_flag;
    end
  end

  assign rsp_valid = (state == S_RESP);

endmodule

// File: doc/alu_sched.md
# alu_sched

Scheduler that shares the single combinational ALU between two requesters (r0, r1). It arbitrates, registers operands onto the ALU inputs, captures result and flags, and returns a tagged response under a valid/ready handshake. The block sits between the control unit and a load/store helper, and owns the ALU's op and operand inputs.

## Interface
- Parameters: none. Data width is fixed at 8 bits and opcode width at 4 bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `r0_valid`, `r1_valid`  in  1  request present.
- `r0_ready`, `r1_ready`  out  1  request accepted this cycle.
- `r0_op`, `r1_op`  in  4  opcode.
- `r0_a`, `r1_a`  in  8  operand A; drives ALU `reg_y`.
- `r0_b`, `r1_b`  in  8  operand B; drives ALU `bus1`.
- `alu_op`  out  4  to ALU.
- `alu_a`, `alu_b`  out  8  to ALU.
- `alu_out`  in  8  from ALU.
- `alu_0_flag`, `alu_o_flag`  in  1  from ALU.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_id`  out  1  requester that issued the op (0/1).
- `rsp_data`  out  8  result.
- `rsp_z`, `rsp_o`  out  1  zero and overflow flags.
- `rsp_err`  out  1  illegal opcode.

## Operation
- Legal opcodes: ADD=0, SUB=1, AND=2, NOT=3, OR=4, MUL=5.
- Opcodes 6–15 are illegal.
- FSM states:
  - IDLE: grant computed combinationally from valids. `rX_ready`=1 only for the granted requester, and only in IDLE. A handshake (`valid && ready`) registers op, a, b and id, then moves to EXEC.
  - EXEC: the registered op and operands drive `alu_*` for exactly one cycle. At the end of the cycle, `alu_out` and the flags are captured into the response registers. Moves to RESP.
  - RESP: `rsp_valid`=1 and all `rsp_*` stay stable until `rsp_ready`=1. Then back to IDLE.
- Illegal opcode: still passes through EXEC, but `alu_op` is driven 0. The response is `rsp_err`=1, `rsp_data`=0, `rsp_z`=0, `rsp_o`=0.
- Flags are passed through unchanged from the ALU:
  - `rsp_o` is the 9th result bit. This is carry for ADD, borrow for SUB, product bit 8 for MUL, and 0 for AND/OR.
  - For NOT, `rsp_o` is the inverted 9th bit of the zero-extended operand A, which is 1.
  - `rsp_z` = (`rsp_data` == 0).
- Outside EXEC, `alu_op`, `alu_a` and `alu_b` are driven to 0.
- Arbitration with `ALU_SCHED_RR_EN`: round-robin pointer. After a grant to X, priority goes to the other requester. The pointer is unchanged when no grant occurs.
- Both valid with pointer=0: r0 wins.
- A requester must hold its valid, op and operands until ready. Deasserting valid before ready is legal; the request is simply not taken.

## Timing
- Reset values: state=IDLE, RR pointer=0.
- Reset values: `r0_ready`=`r1_ready`=0 until the first IDLE evaluation. In IDLE they are combinational and may be 1 immediately after reset release.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_z`=`rsp_o`=`rsp_err`=0, `alu_*`=0.
- Handshake at edge T0 → EXEC during cycle T0..T1 → `rsp_valid`=1 after edge T1.
- Request-to-response latency is 2 cycles. With `rsp_ready` held high, the next accept happens at T3, giving a minimum of 3 cycles per op.
- `rsp_ready` while `rsp_valid`=0 is ignored.
- Requests arriving during EXEC/RESP wait; ready stays 0.
- Reset mid-operation: the in-flight op is dropped with no response, and all outputs return to reset values asynchronously.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority. r0 always wins when both are valid, and the pointer register is not built.

## Structure
- `alu_sched_pkg` holds:
  - opcode localparams (OP_ADD … OP_MUL);
  - `OP_LAST`=5 for legality checks;
  - state enum `sched_state_t` {S_IDLE, S_EXEC, S_RESP}.
- Sub-module `alu_sched_arb` contains the two-input grant logic plus the RR pointer (pointer under the macro).
- The top level holds the FSM, operand/response registers and ALU drive. The ALU is instantiated outside, by the parent.

## Test plan
- r0 ADD a=200 b=100, `rsp_ready`=1 → after 2 cycles: `rsp_id`=0, data=44, o=1, z=0, err=0.
- r1 SUB a=5 b=5 → data=0, z=1, o=0, id=1.
- Both valid, three ops each, RR build → grants r0,r1,r0,r1,r0,r1. Fixed build → r0×3 then r1×3.
- r0 op=9 → err=1, data=0, z=0, o=0; `alu_op` stays 0 through EXEC.
- MUL a=16 b=17 with `rsp_ready`=0 for 4 cycles → data=0x10, o=1, held stable while `rsp_valid`=1; returns to IDLE one cycle after `rsp_ready`=1.
- `rst` pulsed during EXEC → no response, all outputs 0. A new request is accepted normally after reset release.
